fft16_stage2_bfly: RTL and testbench

- Second radix-2 DIT stage of the 16-point FFT. Sits directly downstream of fft16_top_minimal.
- Consumes the flattened stage-1 butterfly outputs st1_yr/st1_yi: 16 lanes x 16-bit signed, lane i at bits [16i+15:16i].
- Computes the eight span-2 butterflies serially, one per cycle, on a single shared twiddle multiplier.
- Presents the stage-2 frame on flattened st2_yr/st2_yi, with a valid/ready handshake on the input and a done pulse on the output.

---
 rtl/fft16_pkg.sv | 71 +++++++
 rtl/fft16_cmul.sv | 58 +++++
 rtl/fft16_stage2_bfly.sv | 190 +++++++++++++++++++
 tb/tb_fft16_stage2_bfly.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// fft16_pkg: shared constants, types and helpers for the 16-point FFT stages.
//   N/LOG2N      - transform size and lane index width
//   DW/TW_W      - default sample width and Q1.14 twiddle width
//   tw_rom()     - W16^k, k = 0..7
//   lane_p/q()   - stage-2 butterfly lane pair from butterfly index b
//   tw_idx()     - stage-2 twiddle exponent from b
//   sat_w()      - clamp a wide signed value to a w-bit two's complement range
package fft16_pkg;

  localparam int unsigned N       = 16;
  localparam int unsigned LOG2N   = 4;
  localparam int unsigned DW      = 16;
  localparam int unsigned TW_W    = 16;
  localparam int unsigned TW_FRAC = 14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } st2_state_e;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } twiddle_t;

  // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in Q1.14
  function automatic twiddle_t tw_rom(input logic [2:0] k);
    twiddle_t r;
    case (k)
      3'd0:    begin r.re =  16'sd16384; r.im =  16'sd0;     end
      3'd1:    begin r.re =  16'sd15137; r.im = -16'sd6270;  end
      3'd2:    begin r.re =  16'sd11585; r.im = -16'sd11585; end
      3'd3:    begin r.re =  16'sd6270;  r.im = -16'sd15137; end
      3'd4:    begin r.re =  16'sd0;     r.im = -16'sd16384; end
      3'd5:    begin r.re = -16'sd6270;  r.im = -16'sd15137; end
      3'd6:    begin r.re = -16'sd11585; r.im = -16'sd11585; end
      default: begin r.re = -16'sd15137; r.im = -16'sd6270;  end
    endcase
    return r;
  endfunction

  // p = 4*(b>>1) + (b&1)
  function automatic logic [LOG2N-1:0] lane_p(input logic [2:0] b);
    return {b[2:1], 1'b0, b[0]};
  endfunction

  // q = p + 2
  function automatic logic [LOG2N-1:0] lane_q(input logic [2:0] b);
    return {b[2:1], 1'b1, b[0]};
  endfunction

  // stage-2 twiddle exponent 4*(b&1)
  function automatic logic [2:0] tw_idx(input logic [2:0] b);
    return {b[0], 2'b00};
  endfunction

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                               input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fft16_cmul.sv
// fft16_cmul: one-cycle registered complex multiply y = w * a with
// per-product rounding (prod + 2^(FRAC-1)) >>> FRAC.
//   clk, rst        - clock, synchronous active-high reset (clears y)
//   en_i            - load a new product on this edge
//   a_re_i/a_im_i   - DW-bit signed sample
//   w_re_i/w_im_i   - TW_W-bit signed twiddle, FRAC fractional bits
//   y_re_o/y_im_o   - registered product, wide enough for |w| = 1 growth
module fft16_cmul #(
  parameter int unsigned DW   = 16,
  parameter int unsigned TW_W = 16,
  parameter int unsigned FRAC = 14,
  localparam int unsigned PW  = DW + TW_W,
  localparam int unsigned RW  = PW + 1 - FRAC,
  localparam int unsigned OW  = RW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_re_i,
  input  logic signed [DW-1:0] a_im_i,
  input  logic signed [TW_W-1:0] w_re_i,
  input  logic signed [TW_W-1:0] w_im_i,
  output logic signed [OW-1:0] y_re_o,
  output logic signed [OW-1:0] y_im_o
);

  localparam logic signed [PW:0] RND_BIAS = (PW+1)'(1) <<< (FRAC - 1);

  function automatic logic signed [RW-1:0] rnd(input logic signed [PW-1:0] v);
    logic signed [PW:0] e;
    e = (PW+1)'(v) + RND_BIAS;
    return RW'(e >>> FRAC);
  endfunction

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [OW-1:0] y_re_d, y_im_d;

  // four partial products, each rounded before the complex sum
  always_comb begin
    p_rr   = PW'(a_re_i) * PW'(w_re_i);
    p_ii   = PW'(a_im_i) * PW'(w_im_i);
    p_ri   = PW'(a_re_i) * PW'(w_im_i);
    p_ir   = PW'(a_im_i) * PW'(w_re_i);
    y_re_d = OW'(rnd(p_rr)) - OW'(rnd(p_ii));
    y_im_d = OW'(rnd(p_ri)) + OW'(rnd(p_ir));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_re_o <= '0;
      y_im_o <= '0;
    end else if (en_i) begin
      y_re_o <= y_re_d;
      y_im_o <= y_im_d;
    end
  end

endmodule

// File: rtl/fft16_stage2_bfly.sv
// fft16_stage2_bfly: second radix-2 DIT stage of the 16-point FFT.
// Snapshots a stage-1 frame, then issues the eight span-2 butterflies one per
// cycle through a shared registered twiddle multiplier and writes lane pairs
// of the stage-2 frame one cycle after each issue.
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - input handshake; in_ready is high in IDLE
//   st1_yr/st1_yi     - 16 x DW stage-1 lanes, lane i at [DW*i +: DW]
//   busy              - high while a frame is being processed
//   out_valid         - one-cycle pulse when st2_yr/st2_yi hold a full frame
//   st2_yr/st2_yi     - 16 x DW stage-2 lanes
module fft16_stage2_bfly #(
  parameter int unsigned DW    = fft16_pkg::DW,
  parameter int unsigned TW_W  = fft16_pkg::TW_W,
  parameter int unsigned SCALE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [fft16_pkg::N*DW-1:0]   st1_yr,
  input  logic [fft16_pkg::N*DW-1:0]   st1_yi,
  output logic                         busy,
  output logic                         out_valid,
  output logic [fft16_pkg::N*DW-1:0]   st2_yr,
  output logic [fft16_pkg::N*DW-1:0]   st2_yi
);

  import fft16_pkg::N;
  import fft16_pkg::LOG2N;
  import fft16_pkg::TW_FRAC;
  import fft16_pkg::st2_state_e;
  import fft16_pkg::ST_IDLE;
  import fft16_pkg::ST_RUN;
  import fft16_pkg::twiddle_t;
  import fft16_pkg::tw_rom;
  import fft16_pkg::lane_p;
  import fft16_pkg::lane_q;
  import fft16_pkg::tw_idx;
  import fft16_pkg::sat_w;

  localparam int unsigned CW  = DW + TW_W - TW_FRAC + 2;  // multiplier output
  localparam int unsigned SW  = CW + 1;                   // butterfly sum
  localparam int unsigned BCW = 4;                        // counts 0..8

  st2_state_e       state_q, state_d;
  logic [BCW-1:0]   b_q, b_d;
  logic             wr_vld_q, wr_vld_d;
  logic [2:0]       wr_b_q, wr_b_d;
  logic             out_valid_d, busy_d, in_ready_d;
  logic             load_c, issue_c;

  logic signed [DW-1:0] x_re_q [N];
  logic signed [DW-1:0] x_im_q [N];
  logic signed [DW-1:0] y_re_q [N];
  logic signed [DW-1:0] y_im_q [N];

  logic [LOG2N-1:0]     iss_q_c, wr_p_c, wr_q_c;
  twiddle_t             tw_c;
  logic signed [CW-1:0] t_re, t_im;
  logic signed [SW-1:0] sum_re_c, sum_im_c, dif_re_c, dif_im_c;
  logic signed [DW-1:0] yp_re_c, yp_im_c, yq_re_c, yq_im_c;

  // SCALE=1 halves (floor); the clamp is then a no-op but kept for safety
  function automatic logic signed [DW-1:0] post(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] s;
    s = (SCALE != 0) ? (v >>> 1) : v;
    return DW'(sat_w(64'(s), DW));
  endfunction

  // next-state: b issues 0..7, b==8 is the drain edge for the last write
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    wr_vld_d    = 1'b0;
    wr_b_d      = wr_b_q;
    out_valid_d = 1'b0;
    load_c      = 1'b0;
    issue_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load_c  = 1'b1;
          b_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (b_q < BCW'(8)) begin
          issue_c  = 1'b1;
          b_d      = b_q + BCW'(1);
          wr_vld_d = 1'b1;
          wr_b_d   = b_q[2:0];
        end else begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d == ST_RUN);
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      b_q       <= '0;
      wr_vld_q  <= 1'b0;
      wr_b_q    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      wr_vld_q  <= wr_vld_d;
      wr_b_q    <= wr_b_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      in_ready  <= in_ready_d;
    end
  end

  // issue side: multiply x[q] by the butterfly's twiddle
  always_comb begin
    iss_q_c = lane_q(b_q[2:0]);
    tw_c    = tw_rom(tw_idx(b_q[2:0]));
  end

  fft16_cmul #(
    .DW   (DW),
    .TW_W (TW_W),
    .FRAC (TW_FRAC)
  ) u_cmul (
    .clk    (clk),
    .rst    (rst),
    .en_i   (issue_c),
    .a_re_i (x_re_q[iss_q_c]),
    .a_im_i (x_im_q[iss_q_c]),
    .w_re_i (TW_W'(tw_c.re)),
    .w_im_i (TW_W'(tw_c.im)),
    .y_re_o (t_re),
    .y_im_o (t_im)
  );

  // write side: x[p] +/- t for the butterfly issued on the previous edge
  always_comb begin
    wr_p_c   = lane_p(wr_b_q);
    wr_q_c   = lane_q(wr_b_q);
    sum_re_c = SW'(x_re_q[wr_p_c]) + SW'(t_re);
    sum_im_c = SW'(x_im_q[wr_p_c]) + SW'(t_im);
    dif_re_c = SW'(x_re_q[wr_p_c]) - SW'(t_re);
    dif_im_c = SW'(x_im_q[wr_p_c]) - SW'(t_im);
    yp_re_c  = post(sum_re_c);
    yp_im_c  = post(sum_im_c);
    yq_re_c  = post(dif_re_c);
    yq_im_c  = post(dif_im_c);
  end

  // frame snapshot and stage-2 result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        x_re_q[i] <= '0;
        x_im_q[i] <= '0;
        y_re_q[i] <= '0;
        y_im_q[i] <= '0;
      end
    end else begin
      if (load_c) begin
        for (int i = 0; i < N; i++) begin
          x_re_q[i] <= st1_yr[i*DW +: DW];
          x_im_q[i] <= st1_yi[i*DW +: DW];
        end
      end
      if (wr_vld_q) begin
        y_re_q[wr_p_c] <= yp_re_c;
        y_im_q[wr_p_c] <= yp_im_c;
        y_re_q[wr_q_c] <= yq_re_c;
        y_im_q[wr_q_c] <= yq_im_c;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign st2_yr[gi*DW +: DW] = y_re_q[gi];
    assign st2_yi[gi*DW +: DW] = y_im_q[gi];
  end

endmodule

// File: tb/tb_fft16_stage2_bfly.sv
// Scoreboard bench for fft16_stage2_bfly: one instance per SCALE setting,
// expected frames computed from the butterfly definition at acceptance time.
module tb_fft16_stage2_bfly;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [255:0] st1_yr, st1_yi;
  logic         in_ready0, busy0, out_valid0;
  logic         in_ready1, busy1, out_valid1;
  logic [255:0] yr0, yi0, yr1, yi1;

  always #5 clk = ~clk;

  fft16_stage2_bfly #(.SCALE(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .st1_yr(st1_yr), .st1_yi(st1_yi), .busy(busy0), .out_valid(out_valid0),
    .st2_yr(yr0), .st2_yi(yi0)
  );

  fft16_stage2_bfly #(.SCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .st1_yr(st1_yr), .st1_yi(st1_yi), .busy(busy1), .out_valid(out_valid1),
    .st2_yr(yr1), .st2_yi(yi1)
  );

  typedef struct packed {
    int           due;
    logic [255:0] r0;
    logic [255:0] i0;
    logic [255:0] r1;
    logic [255:0] i1;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cur_r[16];
  int   cur_i[16];
  bit   last_acc;
  int   n_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint rnd14(input longint v);
    return (v + 64'sd8192) >>> 14;
  endfunction

  function automatic longint post(input longint v, input int scale);
    if (scale != 0) return v >>> 1;
    if (v > 64'sd32767) return 64'sd32767;
    if (v < -64'sd32768) return -64'sd32768;
    return v;
  endfunction

  // y[p] = x[p] + W*x[q], y[q] = x[p] - W*x[q], W = W16^(4j)
  function automatic void model(input int xr[16], input int xi[16], input int scale,
                                output logic [255:0] yr, output logic [255:0] yi);
    yr = '0;
    yi = '0;
    for (int b = 0; b < 8; b++) begin
      int     j, p, q;
      real    ang;
      longint wr, wi, tr, ti;
      j   = b % 2;
      p   = 4 * (b / 2) + j;
      q   = p + 2;
      ang = 2.0 * 3.14159265358979 * real'(4 * j) / 16.0;
      wr  = longint'(16384.0 * $cos(ang));
      wi  = longint'(-16384.0 * $sin(ang));
      tr  = rnd14(longint'(xr[q]) * wr) - rnd14(longint'(xi[q]) * wi);
      ti  = rnd14(longint'(xr[q]) * wi) + rnd14(longint'(xi[q]) * wr);
      yr[16*p +: 16] = 16'(post(longint'(xr[p]) + tr, scale));
      yi[16*p +: 16] = 16'(post(longint'(xi[p]) + ti, scale));
      yr[16*q +: 16] = 16'(post(longint'(xr[p]) - tr, scale));
      yi[16*q +: 16] = 16'(post(longint'(xi[p]) - ti, scale));
    end
  endfunction

  task automatic set_frame();
    for (int i = 0; i < 16; i++) begin
      st1_yr[16*i +: 16] = 16'(cur_r[i]);
      st1_yi[16*i +: 16] = 16'(cur_i[i]);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) begin
      cur_r[i] = 0;
      cur_i[i] = 0;
    end
  endtask

  function automatic int rval(input int mode);
    int sel;
    sel = int'($urandom_range(3));
    if (mode != 0 && sel == 0) return 32767;
    if (mode != 0 && sel == 1) return -32768;
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic rand_frame(input int mode);
    for (int i = 0; i < 16; i++) begin
      cur_r[i] = rval(mode);
      cur_i[i] = rval(mode);
    end
    set_frame();
  endtask

  // one clock; records the expected frame if it is accepted on this edge
  task automatic tick();
    exp_t e;
    last_acc = in_valid && in_ready0 && !rst;
    if (last_acc) begin
      e.due = cyc + 10;
      model(cur_r, cur_i, 0, e.r0, e.i0);
      model(cur_r, cur_i, 1, e.r1, e.i1);
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  // offer the current frame until accepted, then scramble inputs and let it finish
  task automatic send(input string name);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = last_acc;
    end
    in_valid = 1'b0;
    chk({name, "_accepted"}, longint'(got), 64'sd1);
    chk({name, "_busy"}, longint'(busy0), 64'sd1);
    chk({name, "_in_ready"}, longint'(in_ready0), 64'sd0);
    rand_frame(0);
    repeat (10) tick();
  endtask

  // monitor: every out_valid must match the head of the scoreboard on time
  initial begin
    exp_t e;
    bit   exp_now;
    forever begin
      @(posedge clk);
      #1;
      exp_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (out_valid0 || out_valid1 || exp_now) begin
        chk("out_valid_s0", longint'(out_valid0), longint'(exp_now));
        chk("out_valid_s1", longint'(out_valid1), longint'(exp_now));
      end
      if (exp_now) begin
        e = exp_q.pop_front();
        chk("in_ready_at_done", longint'(in_ready0), 64'sd1);
        chk("busy_at_done", longint'(busy0), 64'sd0);
        for (int i = 0; i < 16; i++) begin
          chk($sformatf("s0_re[%0d]", i), longint'($signed(yr0[16*i +: 16])),
              longint'($signed(e.r0[16*i +: 16])));
          chk($sformatf("s0_im[%0d]", i), longint'($signed(yi0[16*i +: 16])),
              longint'($signed(e.i0[16*i +: 16])));
          chk($sformatf("s1_re[%0d]", i), longint'($signed(yr1[16*i +: 16])),
              longint'($signed(e.r1[16*i +: 16])));
          chk($sformatf("s1_im[%0d]", i), longint'($signed(yi1[16*i +: 16])),
              longint'($signed(e.i1[16*i +: 16])));
        end
      end
    end
  end

  task automatic chk_reset_state(input string name);
    chk({name, "_out_valid"}, longint'(out_valid0), 64'sd0);
    chk({name, "_busy"}, longint'(busy0), 64'sd0);
    chk({name, "_in_ready"}, longint'(in_ready0), 64'sd1);
    chk({name, "_st2_zero_s0"}, longint'(|{yr0, yi0}), 64'sd0);
    chk({name, "_st2_zero_s1"}, longint'(|{yr1, yi1}), 64'sd0);
    chk({name, "_busy_s1"}, longint'(busy1), 64'sd0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    n_acc    = 0;
    clear_frame();
    set_frame();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    tick();

    // impulse on lane 0
    clear_frame(); cur_r[0] = 100; set_frame(); send("impulse");
    // W = -j path
    clear_frame(); cur_r[3] = 100; set_frame(); send("lane3");
    // W = 1 path
    clear_frame(); cur_r[2] = 100; set_frame(); send("lane2");
    // overflow: saturate vs halve
    clear_frame(); cur_r[0] = 30000; cur_r[2] = 30000; set_frame(); send("ovf");
    // negative full scale through -j
    clear_frame(); cur_r[3] = -32768; cur_i[1] = 32767; set_frame(); send("negfs");

    for (int k = 0; k < 4; k++) begin rand_frame(0); send("rand"); end
    for (int k = 0; k < 4; k++) begin rand_frame(1); send("edge"); end

    // continuous in_valid with a new frame every cycle
    n_acc    = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rand_frame(0);
      tick();
    end
    in_valid = 1'b0;
    chk("handshake_accepts", longint'(n_acc), 64'sd4);
    repeat (12) tick();

    // reset four cycles after acceptance aborts the frame
    rand_frame(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("abort_accepted", longint'(last_acc), 64'sd1);
    rand_frame(0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    chk_reset_state("abort");
    rst = 1'b0;
    repeat (12) tick();

    // fresh frame after the abort
    rand_frame(0); send("post_abort");

    for (int k = 0; k < 30 && exp_q.size() > 0; k++) tick();
    chk("scoreboard_drained", longint'(exp_q.size()), 64'sd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
